// File: rtl/serial_to_parallel_pkg.sv
// Constants shared by the serializer and deserializer: the COM symbol,
// the default lock depth and the alignment FSM encoding.
package serial_to_parallel_pkg;

  localparam logic [7:0] IDLE_SYM     = 8'hBC;
  localparam int unsigned COM_LOCK_DEF = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } s2p_state_t;

endpackage

// File: rtl/serial_to_parallel.sv
// 1:8 deserializer: hunts for COM alignment, locks after COM_LOCK aligned COMs,
// then emits one registered byte per 8 bit clocks, one edge after the byte's LSB.
module serial_to_parallel #(
  parameter int unsigned COM_LOCK = serial_to_parallel_pkg::COM_LOCK_DEF,
  parameter logic [7:0]  IDLE_SYM = serial_to_parallel_pkg::IDLE_SYM
) (
  input  logic       clk_8f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out_S2P,
  output logic       valid_out,
  output logic       active
);

  import serial_to_parallel_pkg::*;

  localparam logic [2:0] LOCK_N = 3'(COM_LOCK);

  s2p_state_t state, state_nxt;
  logic [7:0] sr;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [2:0] com_cnt, com_cnt_nxt;
  logic [7:0] data_nxt;
  logic       valid_nxt;
  logic       active_nxt;
  logic       is_com;
  logic       boundary;

  assign is_com   = (sr == IDLE_SYM);
  assign boundary = (bit_cnt == 3'd0);

  always_ff @(posedge clk_8f) begin
    if (!reset_L) begin
      state        <= SEARCH;
      sr           <= 8'h00;
      bit_cnt      <= 3'd0;
      com_cnt      <= 3'd0;
      data_out_S2P <= 8'h00;
      valid_out    <= 1'b0;
      active       <= 1'b0;
    end else begin
      state        <= state_nxt;
      sr           <= {sr[6:0], data_in};
      bit_cnt      <= bit_cnt_nxt;
      com_cnt      <= com_cnt_nxt;
      data_out_S2P <= data_nxt;
      valid_out    <= valid_nxt;
      active       <= active_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt + 3'd1;
    com_cnt_nxt = com_cnt;
    data_nxt    = data_out_S2P;
    valid_nxt   = valid_out;
    active_nxt  = active;

    case (state)
      SEARCH: begin
        // sr now holds a full COM, so the next bit starts a byte: phase 1.
        bit_cnt_nxt = 3'd0;
        if (is_com) begin
          bit_cnt_nxt = 3'd1;
          com_cnt_nxt = 3'd1;
          if (LOCK_N == 3'd1) begin
            state_nxt  = ACTIVE;
            active_nxt = 1'b1;
          end else begin
            state_nxt = ALIGN;
          end
        end
      end

      ALIGN: begin
        if (boundary) begin
          if (is_com) begin
            if (com_cnt != 3'd7) com_cnt_nxt = com_cnt + 3'd1;
            if (com_cnt + 3'd1 == LOCK_N) begin
              state_nxt  = ACTIVE;
              active_nxt = 1'b1;
            end
          end else begin
            com_cnt_nxt = 3'd0;
            bit_cnt_nxt = 3'd0;
            state_nxt   = SEARCH;
          end
        end
      end

      ACTIVE: begin
        if (boundary) begin
          if (is_com) begin
            valid_nxt = 1'b0;
          end else begin
            data_nxt  = sr;
            valid_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt   = SEARCH;
        bit_cnt_nxt = 3'd0;
        com_cnt_nxt = 3'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed and randomized stimulus for serial_to_parallel, checked each edge
// against a bit-history reference model.
module tb_serial_to_parallel;

  localparam int CL  = 4;
  localparam int COM = 188;

  logic       clk_8f = 1'b0;
  logic       reset_L;
  logic       data_in;
  logic [7:0] data_out_S2P;
  logic       valid_out;
  logic       active;

  int total = 0;
  int bad   = 0;

  serial_to_parallel #(.COM_LOCK(CL)) dut (
    .clk_8f       (clk_8f),
    .reset_L      (reset_L),
    .data_in      (data_in),
    .data_out_S2P (data_out_S2P),
    .valid_out    (valid_out),
    .active       (active)
  );

  always #5 clk_8f = ~clk_8f;

  // Reference model: mode 0 hunting, 1 counting COMs, 2 locked.
  // Byte boundaries are edges a multiple of 8 after the first accepted COM.
  int         m_mode = 0, m_anchor = 0, m_ncom = 0, m_t = 0;
  logic [7:0] m_dat = 8'h00;
  logic       m_vld = 1'b0, m_act = 1'b0;
  bit         hist[$];

  logic [7:0] cap_dat;
  logic       cap_vld, cap_act;

  function automatic int window();
    int w = 0;
    int n = hist.size();
    for (int i = 0; i < 8; i++) begin
      int idx = n - 8 + i;
      w = w * 2 + ((idx >= 0) ? int'(hist[idx]) : 0);
    end
    return w;
  endfunction

  task automatic model_edge(input bit b, input bit r);
    int  w;
    bit  bnd;
    if (!r) begin
      m_mode = 0; m_anchor = 0; m_ncom = 0; m_t = 0;
      m_dat = 8'h00; m_vld = 1'b0; m_act = 1'b0;
      hist.delete();
    end else begin
      w   = window();
      bnd = ((m_t - m_anchor) % 8) == 0;
      case (m_mode)
        0: if (w == COM) begin
             m_anchor = m_t;
             m_ncom   = 1;
             if (CL == 1) begin m_mode = 2; m_act = 1'b1; end
             else m_mode = 1;
           end
        1: if (bnd) begin
             if (w == COM) begin
               m_ncom++;
               if (m_ncom == CL) begin m_mode = 2; m_act = 1'b1; end
             end else begin
               m_mode = 0;
             end
           end
        default: if (bnd) begin
             if (w == COM) m_vld = 1'b0;
             else begin m_dat = w[7:0]; m_vld = 1'b1; end
           end
      endcase
      hist.push_back(b);
      if (hist.size() > 8) void'(hist.pop_front());
      m_t++;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic r);
    data_in = b;
    reset_L = r;
    @(posedge clk_8f);
    model_edge(b, r);
    #1;
    chk("m_dat", data_out_S2P, m_dat);
    chk("m_vld", {7'd0, valid_out}, {7'd0, m_vld});
    chk("m_act", {7'd0, active}, {7'd0, m_act});
  endtask

  // Captures outputs after the first bit edge, i.e. one edge after the
  // previous byte's LSB; rst_at selects a bit index (0 = MSB) to reset on.
  task automatic send_byte(input logic [7:0] v, input int rst_at);
    for (int i = 7; i >= 0; i--) begin
      step(v[i], ((7 - i) == rst_at) ? 1'b0 : 1'b1);
      if (i == 7) begin
        cap_dat = data_out_S2P;
        cap_vld = valid_out;
        cap_act = active;
      end
      if ((7 - i) == rst_at) begin
        chk("rst_mid_act", {7'd0, active}, 8'd0);
        chk("rst_mid_vld", {7'd0, valid_out}, 8'd0);
        chk("rst_mid_dat", data_out_S2P, 8'h00);
      end
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'($urandom_range(0, 1)), 1'b0);
      chk("rst_dat", data_out_S2P, 8'h00);
      chk("rst_vld", {7'd0, valid_out}, 8'd0);
      chk("rst_act", {7'd0, active}, 8'd0);
    end
  endtask

  initial begin
    reset_L = 1'b0;
    data_in = 1'b0;

    // Reset hold, then idle bits with no COM in them.
    do_reset(3);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
    chk("no_com_act", {7'd0, active}, 8'd0);

    // Lock on continuous COMs, then data A5, 3C, idle.
    do_reset(1);
    for (int i = 0; i < CL; i++) send_byte(8'hBC, -1);
    chk("lock_pre_act", {7'd0, cap_act}, 8'd0);
    send_byte(8'hA5, -1);
    chk("lock_act", {7'd0, cap_act}, 8'd1);
    chk("lock_vld", {7'd0, cap_vld}, 8'd0);
    send_byte(8'h3C, -1);
    chk("a5_dat", cap_dat, 8'hA5);
    chk("a5_vld", {7'd0, cap_vld}, 8'd1);
    send_byte(8'hBC, -1);
    chk("3c_dat", cap_dat, 8'h3C);
    chk("3c_vld", {7'd0, cap_vld}, 8'd1);
    send_byte(8'hBC, -1);
    chk("idle_dat", cap_dat, 8'h3C);
    chk("idle_vld", {7'd0, cap_vld}, 8'd0);

    // Misaligned start: junk bits 1,0,1 ahead of the COM stream.
    do_reset(1);
    step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
    for (int i = 0; i < CL; i++) send_byte(8'hBC, -1);
    send_byte(8'h7E, -1);
    chk("mis_act", {7'd0, cap_act}, 8'd1);
    send_byte(8'hBC, -1);
    chk("mis_dat", cap_dat, 8'h7E);
    chk("mis_vld", {7'd0, cap_vld}, 8'd1);

    // Broken alignment: 2 COMs then 00, then a full lock sequence.
    do_reset(1);
    send_byte(8'hBC, -1); send_byte(8'hBC, -1); send_byte(8'h00, -1);
    for (int i = 0; i < CL; i++) send_byte(8'hBC, -1);
    chk("brk_pre_act", {7'd0, cap_act}, 8'd0);
    send_byte(8'hBC, -1);
    chk("brk_act", {7'd0, cap_act}, 8'd1);

    // Random junk prefixes and random payloads, model-checked every edge.
    for (int r = 0; r < 6; r++) begin
      do_reset(1);
      for (int i = 0, n = $urandom_range(0, 11); i < n; i++) step(1'($urandom_range(0, 1)), 1'b1);
      for (int i = 0; i < CL + 1; i++) send_byte(8'hBC, -1);
      for (int i = 0; i < 16; i++) begin
        logic [7:0] v;
        v = ($urandom_range(0, 3) == 0) ? 8'hBC : 8'($urandom_range(0, 255));
        send_byte(v, -1);
      end
    end

    // Reset on the 5th bit of F0 while locked, then relock.
    do_reset(1);
    for (int i = 0; i < CL; i++) send_byte(8'hBC, -1);
    send_byte(8'h5A, -1);
    send_byte(8'hF0, 4);
    for (int i = 0; i < CL; i++) send_byte(8'hBC, -1);
    chk("relock_pre_act", {7'd0, cap_act}, 8'd0);
    send_byte(8'h99, -1);
    chk("relock_act", {7'd0, cap_act}, 8'd1);
    send_byte(8'hBC, -1);
    chk("relock_dat", cap_dat, 8'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
- Receive-side deserializer. Directly downstream of the 8:1 parallel-to-serial stage.
- Takes the MSB-first serial stream at clk_8f and finds byte alignment by hunting for the idle/COM symbol 8'hBC.
- Declares lock after COM_LOCK consecutive aligned COMs.
- Afterwards emits one parallel byte per 8 clk_8f cycles, with valid_out low for idle symbols.

Parameters:
- COM_LOCK, 4, number of consecutive aligned COM symbols required to enter ACTIVE (legal 1..7).
- IDLE_SYM, 8'hBC, idle/COM symbol used for alignment and as the not-valid marker.

Ports:
- clk_8f  in  1  serial bit clock, 8x byte rate; all state on rising edge
- reset_L  in  1  synchronous active-low reset
- data_in  in  1  serial bit stream, MSB of each byte first
- data_out_S2P  out  8  recovered byte, registered
- valid_out  out  1  high while data_out_S2P holds a non-idle byte, registered
- active  out  1  high once byte alignment is locked, registered

Behaviour:
- One clock (clk_8f); reset is synchronous, active-low (reset_L sampled on rising edge of clk_8f).
- Reset (reset_L==0 at an edge) forces:
  - sr=8'h00, bit_cnt=0, com_cnt=0, state=SEARCH
  - data_out_S2P=8'h00, valid_out=0, active=0
  - Applies mid-operation too: lock is lost immediately, no partial byte is emitted.
- Shift register: every edge out of reset, sr <= {sr[6:0], data_in}. The compare "sr==IDLE_SYM" uses the registered sr.
- bit_cnt (3 bits):
  - Increments mod 8 every cycle in ALIGN/ACTIVE.
  - Held at 0 in SEARCH except on a match.
  - Byte boundary = (bit_cnt==0) in ALIGN/ACTIVE.
- State SEARCH (checked every cycle):
  - If sr==IDLE_SYM: bit_cnt<=1, com_cnt<=1, go to ALIGN.
  - If COM_LOCK==1, go directly to ACTIVE (active<=1) instead.
- State ALIGN (checked only at byte boundary):
  - If sr==IDLE_SYM: com_cnt<=com_cnt+1. When com_cnt+1==COM_LOCK, go to ACTIVE and set active<=1.
  - If sr!=IDLE_SYM: com_cnt<=0, bit_cnt<=0, go to SEARCH. That byte is discarded; the new search starts on the next cycle.
  - Between boundaries, no action apart from shifting.
- State ACTIVE (checked only at byte boundary):
  - If sr==IDLE_SYM: valid_out<=0, data_out_S2P holds its previous value.
  - Else: data_out_S2P<=sr, valid_out<=1.
- ACTIVE is held until reset. There is no loss-of-lock detection in this block.
- Output timing:
  - data_out_S2P and valid_out change only on the edge following a boundary, so each value is stable for exactly 8 clk_8f cycles.
  - Latency: the byte's LSB is shifted in at edge E; the byte appears on data_out_S2P at edge E+1.
  - active rises at the same edge the state becomes ACTIVE.
  - The COM that completes lock produces valid_out=0. The first possible data byte appears 8 cycles later.
- Boundary conditions:
  - In SEARCH, a false 0xBC straddling two bytes may be accepted; the following ALIGN checks reject it.
  - data_in X/Z is not handled.
  - com_cnt saturates; it is never compared beyond COM_LOCK.

Decomposition:
- Shared package:
  - IDLE_SYM constant 8'hBC, shared with the parallel-to-serial stage.
  - State encoding constants SEARCH=2'd0, ALIGN=2'd1, ACTIVE=2'd2.
  - COM_LOCK default.
- No sub-module: shift register, counters and the 3-state FSM stay in one module (~150 lines).

Test Plan:
- Reset: hold reset_L=0 for 3 cycles with random data_in -> data_out_S2P=8'h00, valid_out=0, active=0 every cycle; no change on release until a COM is seen.
- Lock: after reset, stream continuous 0xBC (MSB first) -> active rises 1 edge after the LSB of the 4th COM; valid_out stays 0.
- Data after lock: lock, then send 8'hA5, 8'h3C, 8'hBC -> data_out_S2P=A5, valid=1 for 8 cycles; then 3C, valid=1 for 8 cycles; then data holds 3C, valid=0. Each update lands 1 edge after the byte's LSB.
- Misaligned start: prefix 3 junk bits (1,0,1) before continuous 0xBC -> lock still reached after 4 COMs; following byte 8'h7E recovered exactly.
- Broken alignment: 2 COMs then 8'h00 -> returns to SEARCH, active stays 0; 4 further COMs -> active=1.
- Reset mid-ACTIVE: assert reset_L=0 during the 5th bit of data byte 8'hF0 -> at that edge active=0, valid_out=0, data_out_S2P=00; after release, relock requires 4 new COMs.
